// File: rtl/mac_pkg.sv
// Shared types and widths for the multiply-accumulate stage.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PROD_W = 8;

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand-in / result-out handshake bundle for mac_accumulator.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_x;
  logic [3:0]       in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mac_accumulator_mult.sv
// 4x4 unsigned array multiplier: sum of shifted partial-product rows.
module mac_accumulator_mult
  import mac_pkg::*;
(
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p + (PROD_W'(a) << i);
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Two-stage MAC: registered operand stage, then product accumulation into a
// held frame result (sum, beat count, sticky overflow) on a valid/ready output.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  mac_accumulator_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  logic [CNT_W-1:0]  in_cnt;
  logic [3:0]        s1_x;
  logic [3:0]        s1_y;
  logic              s1_valid;
  logic              s1_term;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt_acc;
  logic              ovf_acc;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              term;
  logic              s2_term;
  logic [PROD_W-1:0] p;
  logic [ACC_W:0]    sum_ext;
  logic              carry;
  state_t            state;
  state_t            state_next;

  assign term     = bus.in_last | (in_cnt == LAST_IDX);
  // Stop taking beats once a terminal beat is in flight; this is what makes
  // an S2 stall unnecessary while the result is held.
  assign in_ready = ~out_valid & ~(s1_valid & s1_term);
  assign accept   = bus.in_valid & in_ready;
  assign s2_term  = s1_valid & s1_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_term  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      in_cnt   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x    <= bus.in_x;
        s1_y    <= bus.in_y;
        s1_term <= term;
        in_cnt  <= term ? '0 : in_cnt + 1'b1;
      end
    end
  end

  mac_accumulator_mult u_mult (
    .a (s1_x),
    .b (s1_y),
    .p (p)
  );

  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(p);
  assign carry   = sum_ext[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt_acc   <= '0;
      ovf_acc   <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (s1_valid) begin
      if (s1_term) begin
        out_sum   <= sum_ext[ACC_W-1:0];
        out_count <= cnt_acc + 1'b1;
        out_ovf   <= ovf_acc | carry;
        acc       <= '0;
        cnt_acc   <= '0;
        ovf_acc   <= 1'b0;
      end else begin
        acc       <= sum_ext[ACC_W-1:0];
        cnt_acc   <= cnt_acc + 1'b1;
        ovf_acc   <= ovf_acc | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    case (state)
      ACCUM: if (s2_term) state_next = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
  assign bus.out_ovf   = out_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: three parameterisations share stimulus,
// each scenario checks the instance it targets.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_x = '0;
  logic [3:0] in_y = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mac_accumulator_if #(.ACC_W(16)) ia ();
  mac_accumulator_if #(.ACC_W(8))  ib ();
  mac_accumulator_if #(.ACC_W(16)) ic ();

  assign ia.in_valid = in_valid; assign ia.in_x = in_x; assign ia.in_y = in_y;
  assign ia.in_last = in_last;   assign ia.out_ready = out_ready;
  assign ib.in_valid = in_valid; assign ib.in_x = in_x; assign ib.in_y = in_y;
  assign ib.in_last = in_last;   assign ib.out_ready = out_ready;
  assign ic.in_valid = in_valid; assign ic.in_x = in_x; assign ic.in_y = in_y;
  assign ic.in_last = in_last;   assign ic.out_ready = out_ready;

  mac_accumulator #(.ACC_W(16), .MAX_LEN(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mac_accumulator #(.ACC_W(8),  .MAX_LEN(16)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  mac_accumulator #(.ACC_W(16), .MAX_LEN(4))  dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [3:0] x, input logic [3:0] y, input logic l);
    in_valid = v; in_x = x; in_y = y; in_last = l;
  endtask

  task automatic pulse_reset();
    beat(1'b0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0d exp=0", ia.out_valid); end
    total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0d exp=1", ia.in_ready); end
    total++; if (ia.out_sum !== 16'd0) begin bad++; $display("FAIL reset_out_sum got=%0d exp=0", ia.out_sum); end
    total++; if (ia.out_count !== 8'd0) begin bad++; $display("FAIL reset_out_count got=%0d exp=0", ia.out_count); end
    total++; if (ia.out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%0d exp=0", ia.out_ovf); end
    total++; if (ic.in_ready !== 1'b1) begin bad++; $display("FAIL reset_c_in_ready got=%0d exp=1", ic.in_ready); end
  endtask

  task automatic test_single();
    pulse_reset();
    out_ready = 1'b0;
    beat(1'b1, 4'd3, 4'd3, 1'b1);
    step();
    beat(1'b0, 4'd0, 4'd0, 1'b0);
    total++; if (ia.in_ready !== 1'b0) begin bad++; $display("FAIL single_ready_e1 got=%0d exp=0", ia.in_ready); end
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_e1 got=%0d exp=0", ia.out_valid); end
    step();
    total++; if (ia.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid_e2 got=%0d exp=1", ia.out_valid); end
    total++; if (ia.out_sum !== 16'd9) begin bad++; $display("FAIL single_sum got=%0d exp=9", ia.out_sum); end
    total++; if (ia.out_count !== 8'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", ia.out_count); end
    total++; if (ia.out_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%0d exp=0", ia.out_ovf); end
    out_ready = 1'b1;
    step();
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL single_handoff_valid got=%0d exp=0", ia.out_valid); end
    total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL single_handoff_ready got=%0d exp=1", ia.in_ready); end
  endtask

  task automatic test_four_beats();
    int unsigned low_cycles = 0;
    pulse_reset();
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL four_ready_beat%0d got=%0d exp=1", i, ia.in_ready); end
      beat(1'b1, 4'd15, 4'd15, i == 3);
      step();
    end
    beat(1'b0, 4'd0, 4'd0, 1'b0);
    if (ia.in_ready === 1'b0) low_cycles++;
    step();
    if (ia.in_ready === 1'b0) low_cycles++;
    total++; if (ia.out_valid !== 1'b1) begin bad++; $display("FAIL four_valid got=%0d exp=1", ia.out_valid); end
    total++; if (ia.out_sum !== 16'd900) begin bad++; $display("FAIL four_sum got=%0d exp=900", ia.out_sum); end
    total++; if (ia.out_count !== 8'd4) begin bad++; $display("FAIL four_count got=%0d exp=4", ia.out_count); end
    step();
    total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL four_ready_after got=%0d exp=1", ia.in_ready); end
    total++; if (low_cycles != 2) begin bad++; $display("FAIL four_ready_low_cycles got=%0d exp=2", low_cycles); end
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL four_valid_after got=%0d exp=0", ia.out_valid); end
  endtask

  task automatic test_back_pressure();
    pulse_reset();
    out_ready = 1'b0;
    beat(1'b1, 4'd5, 4'd5, 1'b0); step();
    beat(1'b1, 4'd6, 4'd6, 1'b1); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    // Offer a beat during hold; it must not be taken.
    beat(1'b1, 4'd9, 4'd9, 1'b1);
    for (int unsigned i = 0; i < 5; i++) begin
      total++; if (ia.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%0d exp=1", i, ia.out_valid); end
      total++; if (ia.out_sum !== 16'd61) begin bad++; $display("FAIL bp_sum_c%0d got=%0d exp=61", i, ia.out_sum); end
      total++; if (ia.out_count !== 8'd2) begin bad++; $display("FAIL bp_count_c%0d got=%0d exp=2", i, ia.out_count); end
      total++; if (ia.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%0d exp=0", i, ia.in_ready); end
      step();
    end
    out_ready = 1'b1;
    step();
    beat(1'b0, 4'd0, 4'd0, 1'b0);
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL bp_handoff_valid got=%0d exp=0", ia.out_valid); end
    total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL bp_handoff_ready got=%0d exp=1", ia.in_ready); end
    step(); step(); step();
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_stray_result got=%0d exp=0", ia.out_valid); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    out_ready = 1'b1;
    beat(1'b1, 4'd15, 4'd15, 1'b0); step();
    beat(1'b1, 4'd15, 4'd15, 1'b1); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    total++; if (ib.out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%0d exp=1", ib.out_valid); end
    total++; if (ib.out_sum !== 8'd194) begin bad++; $display("FAIL ovf_sum got=%0d exp=194", ib.out_sum); end
    total++; if (ib.out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d exp=1", ib.out_ovf); end
    total++; if (ib.out_count !== 8'd2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", ib.out_count); end
    step();
    beat(1'b1, 4'd1, 4'd1, 1'b1); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    total++; if (ib.out_valid !== 1'b1) begin bad++; $display("FAIL ovf_next_valid got=%0d exp=1", ib.out_valid); end
    total++; if (ib.out_sum !== 8'd1) begin bad++; $display("FAIL ovf_next_sum got=%0d exp=1", ib.out_sum); end
    total++; if (ib.out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_next_flag got=%0d exp=0", ib.out_ovf); end
    step();
  endtask

  task automatic test_forced_term();
    pulse_reset();
    out_ready = 1'b1;
    beat(1'b1, 4'd1, 4'd1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) step();
    // Fifth beat stays offered; it waits until the result is handed off.
    total++; if (ic.in_ready !== 1'b0) begin bad++; $display("FAIL forced_ready_e4 got=%0d exp=0", ic.in_ready); end
    step();
    total++; if (ic.out_valid !== 1'b1) begin bad++; $display("FAIL forced_valid1 got=%0d exp=1", ic.out_valid); end
    total++; if (ic.out_sum !== 16'd4) begin bad++; $display("FAIL forced_sum1 got=%0d exp=4", ic.out_sum); end
    total++; if (ic.out_count !== 8'd4) begin bad++; $display("FAIL forced_count1 got=%0d exp=4", ic.out_count); end
    step();
    total++; if (ic.in_ready !== 1'b1) begin bad++; $display("FAIL forced_ready_e6 got=%0d exp=1", ic.in_ready); end
    step();
    beat(1'b1, 4'd2, 4'd2, 1'b1); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    total++; if (ic.out_valid !== 1'b1) begin bad++; $display("FAIL forced_valid2 got=%0d exp=1", ic.out_valid); end
    total++; if (ic.out_sum !== 16'd5) begin bad++; $display("FAIL forced_sum2 got=%0d exp=5", ic.out_sum); end
    total++; if (ic.out_count !== 8'd2) begin bad++; $display("FAIL forced_count2 got=%0d exp=2", ic.out_count); end
    step();
  endtask

  task automatic test_last_at_max();
    pulse_reset();
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      beat(1'b1, 4'd1, 4'd1, i == 3);
      step();
    end
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    total++; if (ic.out_count !== 8'd4) begin bad++; $display("FAIL lastmax_count got=%0d exp=4", ic.out_count); end
    total++; if (ic.out_sum !== 16'd4) begin bad++; $display("FAIL lastmax_sum got=%0d exp=4", ic.out_sum); end
    step();
    beat(1'b1, 4'd3, 4'd3, 1'b1); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    total++; if (ic.out_valid !== 1'b1) begin bad++; $display("FAIL lastmax_next_valid got=%0d exp=1", ic.out_valid); end
    total++; if (ic.out_sum !== 16'd9) begin bad++; $display("FAIL lastmax_next_sum got=%0d exp=9", ic.out_sum); end
    total++; if (ic.out_count !== 8'd1) begin bad++; $display("FAIL lastmax_next_count got=%0d exp=1", ic.out_count); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    pulse_reset();
    out_ready = 1'b1;
    beat(1'b1, 4'd7, 4'd7, 1'b0); step();
    beat(1'b1, 4'd7, 4'd7, 1'b0); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0d exp=0", ia.out_valid); end
    total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0d exp=1", ia.in_ready); end
    beat(1'b1, 4'd2, 4'd5, 1'b1); step();
    beat(1'b0, 4'd0, 4'd0, 1'b0); step();
    total++; if (ia.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_next_valid got=%0d exp=1", ia.out_valid); end
    total++; if (ia.out_sum !== 16'd10) begin bad++; $display("FAIL midrst_next_sum got=%0d exp=10", ia.out_sum); end
    total++; if (ia.out_count !== 8'd1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=1", ia.out_count); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_four_beats();
    test_back_pressure();
    test_overflow();
    test_forced_term();
    test_last_at_max();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
